// File: rtl/pong_frame_renderer.sv
// Pong frame renderer: per-frame latched game state, border blink, game-over flash.
// Ports: clk/reset(active-low async), pixel_x/y, video_on, hsync_in/vsync_in,
//   posx/posy, posbarraiy/posbarrady, vidasi/vidasd -> hsync, vsync, rgb, frame_tick.
module pong_frame_renderer #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BORDER       = 10,
  parameter int BALL_SIZE    = 12,
  parameter int PAD_W        = 10,
  parameter int PAD_H        = 100,
  parameter int PADL_X       = 30,
  parameter int PADR_X       = 600,
  parameter int MAX_LIVES    = 7,
  parameter int LIFE_W       = 5,
  parameter int LIFE_PITCH   = 10,
  parameter int RGB_W        = 3,
  parameter int BLINK_FRAMES = 8,
  parameter int BLINK_COUNT  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic             video_on,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [9:0]       posx,
  input  logic [9:0]       posy,
  input  logic [9:0]       posbarraiy,
  input  logic [9:0]       posbarrady,
  input  logic [2:0]       vidasi,
  input  logic [2:0]       vidasd,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_tick
);

  localparam logic [10:0] BD  = 11'(BORDER);
  localparam logic [10:0] HB  = 11'(H_RES - BORDER);
  localparam logic [10:0] VB  = 11'(V_RES - BORDER);
  localparam logic [10:0] BS  = 11'(BALL_SIZE);
  localparam logic [10:0] PLX = 11'(PADL_X);
  localparam logic [10:0] PRX = 11'(PADR_X);
  localparam logic [10:0] PW  = 11'(PAD_W);
  localparam logic [10:0] PH  = 11'(PAD_H);
  localparam logic [2:0]  MAXL = 3'(MAX_LIVES);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam int CW = $clog2(BLINK_COUNT + 1);
  localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] CMAX = CW'(BLINK_COUNT - 1);

  typedef enum logic [1:0] {B_IDLE, B_ON, B_OFF} blink_t;

  typedef struct packed {
    logic ball;
    logic bl;
    logic br;
    logic pip;
    logic band;
    logic pl;
    logic pr;
    logic von;
    logic hs;
    logic vs;
    logic tk;
  } s1_t;

  logic          tick;
  logic [2:0]    lv_new [2];
  logic [9:0]    sh_bx, sh_by, sh_pl, sh_pr;
  logic [2:0]    sh_lv  [2];
  logic [2:0]    prev   [2];
  blink_t        bst    [2];
  logic [FW-1:0] fcnt   [2];
  logic [CW-1:0] bcnt   [2];
  logic [FW-1:0] gcnt;
  logic          go_ph;
  logic          tick_d;
  logic [10:0]   x, y;
  logic          top_c, pip_c;
  s1_t           s1_c, s1;
  logic [2:0]    col;
  logic          go;

  assign tick = (pixel_x == 10'd0) && (pixel_y == 10'(V_RES));
  assign lv_new[0] = (vidasi > MAXL) ? MAXL : vidasi;
  assign lv_new[1] = (vidasd > MAXL) ? MAXL : vidasd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_bx <= '0;
      sh_by <= '0;
      sh_pl <= '0;
      sh_pr <= '0;
      gcnt  <= '0;
      go_ph <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        sh_lv[s] <= '0;
        prev[s]  <= MAXL;
        bst[s]   <= B_IDLE;
        fcnt[s]  <= '0;
        bcnt[s]  <= '0;
      end
    end else if (tick) begin
      sh_bx <= posx;
      sh_by <= posy;
      sh_pl <= posbarraiy;
      sh_pr <= posbarrady;
      if (gcnt == FMAX) begin
        gcnt  <= '0;
        go_ph <= ~go_ph;
      end else begin
        gcnt <= gcnt + 1'b1;
      end
      for (int s = 0; s < 2; s++) begin
        sh_lv[s] <= lv_new[s];
        prev[s]  <= lv_new[s];
        if (lv_new[s] < prev[s]) begin
          bst[s]  <= B_ON;
          fcnt[s] <= '0;
          bcnt[s] <= '0;
        end else begin
          unique case (bst[s])
            B_ON: begin
              if (fcnt[s] == FMAX) begin
                bst[s]  <= B_OFF;
                fcnt[s] <= '0;
              end else begin
                fcnt[s] <= fcnt[s] + 1'b1;
              end
            end
            B_OFF: begin
              if (fcnt[s] == FMAX) begin
                fcnt[s] <= '0;
                if (bcnt[s] == CMAX) begin
                  bst[s] <= B_IDLE;
                end else begin
                  bst[s]  <= B_ON;
                  bcnt[s] <= bcnt[s] + 1'b1;
                end
              end else begin
                fcnt[s] <= fcnt[s] + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign x     = {1'b0, pixel_x};
  assign y     = {1'b0, pixel_y};
  assign top_c = y < BD;

  always_comb begin
    pip_c = 1'b0;
    for (int k = 0; k < MAX_LIVES; k++) begin
      if (top_c && 32'(sh_lv[0]) > k
          && x >= 11'(BORDER + k * LIFE_PITCH)
          && x <= 11'(BORDER + k * LIFE_PITCH + LIFE_W))
        pip_c = 1'b1;
      if (top_c && 32'(sh_lv[1]) > k
          && x >= 11'(H_RES - BORDER - k * LIFE_PITCH - LIFE_W)
          && x <= 11'(H_RES - BORDER - k * LIFE_PITCH))
        pip_c = 1'b1;
    end
  end

  always_comb begin
    s1_c      = '0;
    s1_c.ball = (x > {1'b0, sh_bx}) && (x < {1'b0, sh_bx} + BS)
             && (y > {1'b0, sh_by}) && (y < {1'b0, sh_by} + BS);
    s1_c.bl   = x < BD;
    s1_c.br   = x >= HB;
    s1_c.pip  = pip_c;
    s1_c.band = top_c || (y >= VB);
    s1_c.pl   = (x >= PLX) && (x < PLX + PW)
             && (y >= {1'b0, sh_pl}) && (y <= {1'b0, sh_pl} + PH);
    s1_c.pr   = (x >= PRX) && (x < PRX + PW)
             && (y >= {1'b0, sh_pr}) && (y <= {1'b0, sh_pr} + PH);
    s1_c.von  = video_on;
    s1_c.hs   = hsync_in;
    s1_c.vs   = vsync_in;
    s1_c.tk   = tick;
  end

  assign go = (sh_lv[0] == 3'd0) || (sh_lv[1] == 3'd0);

  always_comb begin
    col = 3'b000;
    if (!s1.von)      col = 3'b000;
    else if (s1.ball) col = 3'b111;
    else if (s1.bl)   col = (bst[0] == B_ON) ? 3'b100 : 3'b010;
    else if (s1.br)   col = (bst[1] == B_ON) ? 3'b100 : 3'b010;
    else if (s1.pip)  col = 3'b111;
    else if (s1.band) col = 3'b010;
    else if (s1.pl)   col = 3'b110;
    else if (s1.pr)   col = 3'b101;
    else if (go && go_ph) col = 3'b001;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1         <= '0;
      tick_d     <= 1'b0;
      rgb        <= '0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      s1         <= s1_c;
      tick_d     <= s1.tk;
      rgb        <= RGB_W'(col);
      hsync      <= s1.hs;
      vsync      <= s1.vs;
      frame_tick <= s1.tk;
    end
  end

endmodule
